// File: rtl/dec_seq_pkg.sv
// Shared definitions for the registered one-hot decoder / scanner.
package dec_seq_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Dwell counter width; DWELL is limited to 1..255.
  localparam int DWELL_CW = 8;

  // The scan state doubles as the previous-Mode register:
  // ENTER = last enabled cycle was direct (or reset), STEP = already scanning.
  typedef enum logic {
    SC_ENTER = 1'b0,
    SC_STEP  = 1'b1
  } scan_state_t;

  // Number of decoded output lines for an N-bit select.
  function automatic int out_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/dec_seq_dwell_timer.sv
// Dwell counter: counts enabled scan cycles, ticks on the last cycle of a line.
module dwell_timer
  import dec_seq_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam logic [DWELL_CW-1:0] TC = DWELL_CW'(DWELL - 1);

  logic [DWELL_CW-1:0] r_cnt;

  assign tick = run && (r_cnt == TC);

  // Count while running, restart after terminal count, clear on demand.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dec_seq.sv
// Registered N-to-2^N one-hot decoder with enable and auto-scan mode.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SC_ENTER | previous enabled cycle was direct (or reset); next scan
//          | cycle restarts at index 0
// SC_STEP  | scanning; index advances when the dwell timer ticks
module dec_seq
  import dec_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    En,
  input  logic                    Mode,
  input  logic [N-1:0]            W,
  output logic [0:out_width(N)-1] Y,
  output logic [N-1:0]            Idx,
  output logic                    Wrap
);

  localparam int NY = out_width(N);

  scan_state_t     r_state;
  scan_state_t     w_state_nxt;
  logic [N-1:0]    r_idx;
  logic [N-1:0]    w_idx_nxt;
  logic [0:NY-1]   r_y;
  logic [0:NY-1]   w_y_nxt;
  logic            r_wrap;
  logic            w_wrap_nxt;
  logic            w_run;
  logic            w_clr;
  logic            w_tick;

  // Dwell runs only while stepping; any enabled non-stepping cycle restarts it.
  assign w_run = En && (Mode == MODE_SCAN) && (r_state == SC_STEP);
  assign w_clr = En && ((Mode == MODE_DIRECT) || (r_state == SC_ENTER));

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .run  (w_run),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // Next state, next index, one-hot decode and wrap pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_y_nxt     = '0;
    w_wrap_nxt  = 1'b0;
    if (En) begin
      if (Mode == MODE_DIRECT) begin
        w_state_nxt = SC_ENTER;
        w_idx_nxt   = W;
      end else if (r_state == SC_ENTER) begin
        w_state_nxt = SC_STEP;
        w_idx_nxt   = '0;
      end else if (w_tick) begin
        w_idx_nxt  = r_idx + 1'b1;
        w_wrap_nxt = (r_idx == {N{1'b1}});
      end
      // Y follows the index, so resuming after a pause restores the line.
      w_y_nxt[w_idx_nxt] = 1'b1;
    end
  end

  // Output and state registers; Idx and scan state hold while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SC_ENTER;
      r_idx   <= '0;
      r_y     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_y     <= w_y_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign Y    = r_y;
  assign Idx  = r_idx;
  assign Wrap = r_wrap;

endmodule

// File: tb/tb_dec_seq.sv
// Bench for dec_seq: three configurations (N4/D4, N2/D1, N3/D5) driven in
// parallel, checked every cycle against an elapsed-time model.
module tb_dec_seq;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [3:0]  w;

  logic [0:15] y0;
  logic [3:0]  idx0;
  logic        wrap0;
  logic [0:3]  y1;
  logic [1:0]  idx1;
  logic        wrap1;
  logic [0:7]  y2;
  logic [2:0]  idx2;
  logic        wrap2;

  int tests = 0;
  int fails = 0;

  dec_seq #(.N(4), .DWELL(4)) u0 (
    .clk(clk), .rst(rst), .En(en), .Mode(mode), .W(w),
    .Y(y0), .Idx(idx0), .Wrap(wrap0));
  dec_seq #(.N(2), .DWELL(1)) u1 (
    .clk(clk), .rst(rst), .En(en), .Mode(mode), .W(w[1:0]),
    .Y(y1), .Idx(idx1), .Wrap(wrap1));
  dec_seq #(.N(3), .DWELL(5)) u2 (
    .clk(clk), .rst(rst), .En(en), .Mode(mode), .W(w[2:0]),
    .Y(y2), .Idx(idx2), .Wrap(wrap2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per instance, t = enabled scan cycles since ENTER;
  // index = (t / DWELL) mod 2^N, wrap whenever t is a positive multiple of the period.
  int cfg_n [3] = '{4, 2, 3};
  int cfg_d [3] = '{4, 1, 5};
  int m_idx [3];
  int m_on  [3];
  int m_wrap[3];
  int m_t   [3];
  int m_scan[3];
  bit started = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int lines;
      lines = 1 << cfg_n[k];
      if (rst) begin
        m_idx[k] = 0; m_on[k] = 0; m_wrap[k] = 0; m_t[k] = 0; m_scan[k] = 0;
      end else if (!en) begin
        m_on[k] = 0; m_wrap[k] = 0;
      end else if (!mode) begin
        m_idx[k] = int'(w) % lines; m_on[k] = 1; m_wrap[k] = 0;
        m_t[k] = 0; m_scan[k] = 0;
      end else if (m_scan[k] == 0) begin
        m_scan[k] = 1; m_t[k] = 0; m_idx[k] = 0; m_on[k] = 1; m_wrap[k] = 0;
      end else begin
        m_t[k]    = m_t[k] + 1;
        m_idx[k]  = (m_t[k] / cfg_d[k]) % lines;
        m_wrap[k] = (m_t[k] % (cfg_d[k] * lines) == 0) ? 1 : 0;
        m_on[k]   = 1;
      end
    end
    started = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic [31:0] gy, input int gidx, input logic gw);
    logic [31:0] ey;
    ey = m_on[k] ? (32'd1 << m_idx[k]) : 32'd0;
    check($sformatf("u%0d_y", k), gy, ey);
    check($sformatf("u%0d_idx", k), gidx, m_idx[k]);
    check($sformatf("u%0d_wrap", k), {31'd0, gw}, m_wrap[k]);
    check($sformatf("u%0d_onehot", k), ($countones(gy) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Per-cycle compare; Y is re-packed so bit i of gy is line Y[i].
  always @(negedge clk) begin
    if (started) begin
      logic [31:0] g;
      g = '0; for (int i = 0; i < 16; i++) g[i] = y0[i];
      check_inst(0, g, int'(idx0), wrap0);
      g = '0; for (int i = 0; i < 4; i++) g[i] = y1[i];
      check_inst(1, g, int'(idx1), wrap1);
      g = '0; for (int i = 0; i < 8; i++) g[i] = y2[i];
      check_inst(2, g, int'(idx2), wrap2);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int nw0, nw1, nw2;

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0; w = 4'hA;
    step(); step();
    check("rst_y", {16'd0, y0}, 32'h0);
    check("rst_idx", {28'd0, idx0}, 32'h0);
    check("rst_wrap", {31'd0, wrap0}, 32'h0);

    rst = 1'b0;
    step();
    check("rel_y", {16'd0, y0}, 32'h0020);
    check("rel_idx", {28'd0, idx0}, 32'hA);

    for (int v = 0; v < 16; v++) begin
      w = 4'(v);
      step(); step();
      check("sweep_idx", {28'd0, idx0}, v);
      check("sweep_y", {16'd0, y0}, 32'h8000 >> v);
    end

    en = 1'b0; w = 4'b1001;
    step();
    check("dis_y", {16'd0, y0}, 32'h0);
    check("dis_idx", {28'd0, idx0}, 32'd15);

    en = 1'b1; mode = 1'b1;
    step();
    check("enter_idx", {28'd0, idx0}, 32'd0);
    check("enter_y", {16'd0, y0}, 32'h8000);
    nw0 = 0; nw1 = 0; nw2 = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      nw0 += int'(wrap0); nw1 += int'(wrap1); nw2 += int'(wrap2);
      if (i == 3)  check("dwell3_idx", {28'd0, idx0}, 32'd0);
      if (i == 4)  check("dwell4_idx", {28'd0, idx0}, 32'd1);
      if (i == 63) check("pre_wrap_idx", {28'd0, idx0}, 32'd15);
      if (i == 64) begin
        check("wrap_idx", {28'd0, idx0}, 32'd0);
        check("wrap_pulse", {31'd0, wrap0}, 32'd1);
      end
    end
    check("wrap_count_n4d4", nw0, 32'd1);
    check("wrap_count_n2d1", nw1, 32'd16);
    check("wrap_count_n3d5", nw2, 32'd1);

    // 22 more cycles: index 5 with dwell count 2.
    for (int i = 0; i < 22; i++) step();
    check("prepause_idx", {28'd0, idx0}, 32'd5);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pause_y", {16'd0, y0}, 32'h0);
      check("pause_idx", {28'd0, idx0}, 32'd5);
    end
    en = 1'b1;
    step();
    check("resume1_idx", {28'd0, idx0}, 32'd5);
    check("resume1_y", {16'd0, y0}, 32'h0400);
    step();
    check("resume2_idx", {28'd0, idx0}, 32'd6);

    for (int i = 0; i < 4; i++) step();
    check("scan7_idx", {28'd0, idx0}, 32'd7);
    mode = 1'b0; w = 4'd3;
    step();
    check("m2d_y", {16'd0, y0}, 32'h1000);
    check("m2d_idx", {28'd0, idx0}, 32'd3);
    mode = 1'b1;
    step();
    check("reenter_idx", {28'd0, idx0}, 32'd0);
    check("reenter_y", {16'd0, y0}, 32'h8000);
    for (int i = 0; i < 45; i++) step();

    // Mode change while disabled: no re-entry until enabled.
    en = 1'b0; mode = 1'b0; w = 4'd9;
    step(); step();
    mode = 1'b1;
    step();
    en = 1'b1;
    for (int i = 0; i < 12; i++) step();

    rst = 1'b1;
    step();
    check("midscan_rst_y", {16'd0, y0}, 32'h0);
    check("midscan_rst_idx", {28'd0, idx0}, 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_enter", {28'd0, idx0}, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
